// File: rtl/aer_pkg.sv
// Shared types and constants for the AER event sender (FSM states, encoder reset address).
package aer_pkg;

  localparam int AER_ADDR_W = 10;

  // Address the rank-order encoder emits as an AER reset event.
  localparam logic [AER_ADDR_W-1:0] AER_RST_ADDR = 10'h1FF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } aer_state_t;

endpackage

// File: rtl/aer_evt_fifo.sv
// Small synchronous event FIFO; pointers carry one extra wrap bit to tell full from empty.
module aer_evt_fifo
  import aer_pkg::*;
#(
  parameter int ADDR_W     = AER_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_mem [FIFO_DEPTH];
  logic [IDX_W:0]    r_wr_ptr;
  logic [IDX_W:0]    r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                 (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign dout  = r_mem[r_rd_ptr[IDX_W-1:0]];

  // A pop frees the head slot this cycle, so a push into a full FIFO is still accepted.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/aer_event_sender.sv
// Buffers encoder address pulses and replays each as a four-phase AER REQ/ACK handshake.
// Build option: define AER_TIMEOUT_EN to abandon a request whose ACK does not arrive in time.
module aer_event_sender
  import aer_pkg::*;
#(
  parameter int ADDR_W      = AER_ADDR_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EVT_VALID,
  input  logic [ADDR_W-1:0] EVT_ADDR,
  output logic              AERIN_CTRL_BUSY,
  output logic [ADDR_W-1:0] AERIN_ADDR,
  output logic              AERIN_REQ,
  input  logic              AERIN_ACK,
  output logic [CNT_W-1:0]  EVT_CNT,
  output logic              OVERFLOW,
  output logic              TIMEOUT_ERR,
  output logic [1:0]        o_dbg_state
);

  logic              r_valid_d;
  logic              r_ack_meta;
  logic              r_ack_s;
  logic              r_ovf;
  aer_state_t        r_state;
  aer_state_t        w_state_nxt;
  logic              r_req;
  logic              w_req_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_head;
  logic              w_to_fire;

  // EVT_ADDR is qualified the cycle after EVT_VALID, i.e. while r_valid_d is high.
  aer_evt_fifo #(
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk(CLK),
    .i_rst(RST),
    .push (r_valid_d),
    .pop  (w_pop),
    .din  (EVT_ADDR),
    .dout (w_head),
    .full (w_full),
    .empty(w_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid_d  <= 1'b0;
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_valid_d  <= EVT_VALID;
      r_ack_meta <= AERIN_ACK;
      r_ack_s    <= r_ack_meta;
      r_ovf      <= r_ovf | (r_valid_d & w_full & ~w_pop);
    end
  end

`ifdef AER_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_err;

  // r_to_cnt holds how many REQ cycles have already elapsed; fire on the last allowed one.
  assign w_to_fire = (r_state == REQ) && !r_ack_s &&
                     ((r_to_cnt + 1'b1) == TO_W'(ACK_TIMEOUT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == REQ) ? r_to_cnt + 1'b1 : '0;
      r_to_err <= r_to_err | w_to_fire;
    end
  end

  assign TIMEOUT_ERR = r_to_err;
`else
  assign w_to_fire   = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_addr_nxt  = w_head;
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (r_ack_s) begin
          w_req_nxt   = 1'b0;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = RELEASE;
        end else if (w_to_fire) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!r_ack_s) w_state_nxt = IDLE;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Includes raw EVT_VALID so the encoder sees busy in the very cycle it fires.
  assign AERIN_CTRL_BUSY = EVT_VALID | r_valid_d | ~w_empty | (r_state != IDLE);
  assign AERIN_ADDR      = r_addr;
  assign AERIN_REQ       = r_req;
  assign EVT_CNT         = r_cnt;
  assign OVERFLOW        = r_ovf;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_aer_event_sender.sv
// Bench for aer_event_sender: handshake timing table, encoder/core models with a scoreboard,
// and hand sequences for overflow, reset and ACK timeout (timeout only with AER_TIMEOUT_EN).
module tb_aer_event_sender;

  localparam int ADDR_W      = 10;
  localparam int FIFO_DEPTH  = 4;
  localparam int ACK_TIMEOUT = 10;
  localparam int CNT_W       = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              evt_valid;
  logic [ADDR_W-1:0] evt_addr;
  logic              aerin_ctrl_busy;
  logic [ADDR_W-1:0] aerin_addr;
  logic              aerin_req;
  logic              aerin_ack;
  logic [CNT_W-1:0]  evt_cnt;
  logic              overflow;
  logic              timeout_err;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  aer_event_sender #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .EVT_VALID      (evt_valid),
    .EVT_ADDR       (evt_addr),
    .AERIN_CTRL_BUSY(aerin_ctrl_busy),
    .AERIN_ADDR     (aerin_addr),
    .AERIN_REQ      (aerin_req),
    .AERIN_ACK      (aerin_ack),
    .EVT_CNT        (evt_cnt),
    .OVERFLOW       (overflow),
    .TIMEOUT_ERR    (timeout_err),
    .o_dbg_state    (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model state ----------------
  int                n_vec = 0;
  int                n_err = 0;
  logic [ADDR_W-1:0] exp_q[$];   // addresses the core must receive, in order
  logic [ADDR_W-1:0] plan_q[$];  // addresses the encoder model still has to issue
  int                delivered = 0;
  bit                auto_ack = 1'b0;
  bit                ack_hold = 1'b0;
  int                core_wait = 0;
  int                enc_phase = 0;
  int                enc_gap = 0;
  logic [ADDR_W-1:0] enc_addr;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                ack_dly;
    int                exp_rise;
    int                exp_high;
    int                exp_rel;
    int                exp_cnt;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Core side: acknowledge each REQ after a random delay, release ACK after REQ falls.
  task automatic core_step();
    if (!auto_ack) return;
    if (aerin_req && !aerin_ack) begin
      if (ack_hold) begin
      end else if (core_wait > 0) begin
        core_wait--;
      end else begin
        if (exp_q.size() == 0) check("sb_unexpected_evt", 32'(aerin_addr), 32'hFFFF_FFFF);
        else check("sb_addr", 32'(aerin_addr), 32'(exp_q.pop_front()));
        delivered++;
        aerin_ack = 1'b1;
        core_wait = $urandom_range(0, 3);
      end
    end else if (!aerin_req && aerin_ack) begin
      if (core_wait > 0) core_wait--;
      else begin
        aerin_ack = 1'b0;
        core_wait = $urandom_range(0, 3);
      end
    end
  endtask

  // Encoder side: fire only when not busy; address follows one cycle after the pulse.
  task automatic enc_step();
    logic busy_now;
    busy_now = aerin_ctrl_busy;
    if (enc_phase == 1) begin
      evt_valid = 1'b0;
      evt_addr  = enc_addr;
      exp_q.push_back(enc_addr);
      enc_phase = 0;
    end else begin
      evt_valid = 1'b0;
      evt_addr  = ADDR_W'($urandom);
      if (plan_q.size() > 0) begin
        if (enc_gap > 0) enc_gap--;
        else if (!busy_now) begin
          evt_valid = 1'b1;
          enc_addr  = plan_q.pop_front();
          enc_phase = 1;
          enc_gap   = $urandom_range(0, 4);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    core_step();
    enc_step();
  endtask

  // Forced back-to-back events first..first+n-1, ignoring BUSY.
  task automatic burst(input int first, input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      core_step();
      evt_valid = (k < n);
      evt_addr  = (k == 0) ? ADDR_W'($urandom) : ADDR_W'(first + k - 1);
    end
    @(negedge clk);
    core_step();
    evt_valid = 1'b0;
    evt_addr  = ADDR_W'($urandom);
  endtask

  task automatic drain(input string name, input int limit);
    int  k;
    bit  done;
    k = 0;
    done = 1'b0;
    while (!done && k < limit) begin
      done = (plan_q.size() == 0) && (enc_phase == 0) && (exp_q.size() == 0) &&
             !aerin_ctrl_busy && !aerin_ack;
      if (!done) begin
        step();
        k++;
      end
    end
    check({name, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic apply_reset(input logic ack_level);
    @(negedge clk);
    rst       = 1'b1;
    evt_valid = 1'b0;
    aerin_ack = ack_level;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    plan_q.delete();
    enc_phase = 0;
    core_wait = 0;
    delivered = 0;
  endtask

  // One event with a manually driven ACK; returns REQ rise cycle, REQ high length and
  // number of BUSY cycles after REQ falls.
  task automatic run_single(input logic [ADDR_W-1:0] addr, input int dly,
                            output int rise, output int high, output int rel,
                            output logic [ADDR_W-1:0] seen, output bit stable);
    int c;
    rise = -1; high = 0; rel = 0; seen = '0; stable = 1'b1;
    @(negedge clk); evt_valid = 1'b1; evt_addr = ~addr; c = 0;
    @(negedge clk); evt_valid = 1'b0; evt_addr = addr;  c = 1;
    while (!aerin_req && c < 20) begin
      @(negedge clk);
      evt_addr = ADDR_W'($urandom);
      c++;
    end
    if (aerin_req) rise = c;
    seen = aerin_addr;
    while (aerin_req && high < 40) begin
      if (aerin_addr !== seen) stable = 1'b0;
      if (high == dly) aerin_ack = 1'b1;
      high++;
      @(negedge clk);
    end
    aerin_ack = 1'b0;
    while (aerin_ctrl_busy && rel < 40) begin
      if (aerin_addr !== seen) stable = 1'b0;
      rel++;
      @(negedge clk);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int                rise, high, rel, h, k;
    logic [ADDR_W-1:0] seen;
    bit                stable;

    vecs[0] = '{addr: 10'h1FF, ack_dly: 5, exp_rise: 3, exp_high: 8, exp_rel: 3, exp_cnt: 1};
    vecs[1] = '{addr: 10'h1FF, ack_dly: 0, exp_rise: 3, exp_high: 3, exp_rel: 3, exp_cnt: 2};
    vecs[2] = '{addr: 10'h023, ack_dly: 2, exp_rise: 3, exp_high: 5, exp_rel: 3, exp_cnt: 3};
    vecs[3] = '{addr: 10'h3FF, ack_dly: 1, exp_rise: 3, exp_high: 4, exp_rel: 3, exp_cnt: 4};

    rst = 1'b1; evt_valid = 1'b1; evt_addr = '0; aerin_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(aerin_req), 32'd0);
    check("rst_addr", 32'(aerin_addr), 32'd0);
    check("rst_cnt", 32'(evt_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_to", 32'(timeout_err), 32'd0);
    check("rst_busy_valid", 32'(aerin_ctrl_busy), 32'd1);
    evt_valid = 1'b0;
    #1;
    check("rst_busy_idle", 32'(aerin_ctrl_busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(aer_pkg::IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Handshake timing table
    for (int i = 0; i < 4; i++) begin
      run_single(vecs[i].addr, vecs[i].ack_dly, rise, high, rel, seen, stable);
      check($sformatf("v%0d_req_rise", i), 32'(rise), 32'(vecs[i].exp_rise));
      check($sformatf("v%0d_addr", i), 32'(seen), 32'(vecs[i].addr));
      check($sformatf("v%0d_req_high", i), 32'(high), 32'(vecs[i].exp_high));
      check($sformatf("v%0d_release", i), 32'(rel), 32'(vecs[i].exp_rel));
      check($sformatf("v%0d_addr_stable", i), 32'(stable), 32'd1);
      check($sformatf("v%0d_cnt", i), 32'(evt_cnt), 32'(vecs[i].exp_cnt));
      delivered++;
    end

    // Encoder reset sequence plus a pixel, BUSY-respecting
    auto_ack = 1'b1;
    plan_q.push_back(aer_pkg::AER_RST_ADDR);
    plan_q.push_back(aer_pkg::AER_RST_ADDR);
    plan_q.push_back(10'h023);
    drain("seq3", 500);
    check("seq3_cnt", 32'(evt_cnt), 32'(CNT_W'(delivered)));
    check("seq3_ovf", 32'(overflow), 32'd0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 40; i++)
      plan_q.push_back(($urandom_range(0, 3) == 0) ? aer_pkg::AER_RST_ADDR : ADDR_W'($urandom));
    drain("rand", 4000);
    check("rand_cnt", 32'(evt_cnt), 32'(CNT_W'(delivered)));
    check("rand_ovf", 32'(overflow), 32'd0);

    // Overflow: one in flight, four buffered, sixth dropped
    ack_hold = 1'b1;
    for (int i = 1; i <= 5; i++) exp_q.push_back(ADDR_W'(i));
    burst(1, 5);
    step(); step();
    check("ovf_inflight_req", 32'(aerin_req), 32'd1);
    check("ovf_inflight_addr", 32'(aerin_addr), 32'd1);
    check("ovf_before_drop", 32'(overflow), 32'd0);
    burst(6, 1);
    step(); step();
    check("ovf_after_drop", 32'(overflow), 32'd1);
    ack_hold = 1'b0;
    drain("ovf", 500);
    check("ovf_cnt", 32'(evt_cnt), 32'(CNT_W'(delivered)));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-handshake with two events queued
    apply_reset(1'b0);
    check("rst2_ovf_clear", 32'(overflow), 32'd0);
    ack_hold = 1'b1;
    burst(16, 3);
    step(); step();
    check("midrst_req_before", 32'(aerin_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_req_async", 32'(aerin_req), 32'd0);
    check("midrst_cnt", 32'(evt_cnt), 32'd0);
    check("midrst_busy", 32'(aerin_ctrl_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    delivered = 0;
    ack_hold = 1'b0;
    repeat (5) step();
    check("midrst_fifo_flushed_req", 32'(aerin_req), 32'd0);
    check("midrst_fifo_flushed_busy", 32'(aerin_ctrl_busy), 32'd0);
    plan_q.push_back(10'h2A5);
    drain("postrst", 500);
    check("postrst_cnt", 32'(evt_cnt), 32'd1);

    // ACK already high when reset releases
    auto_ack = 1'b0;
    apply_reset(1'b1);
    repeat (4) @(negedge clk);
    check("ackhigh_req", 32'(aerin_req), 32'd0);
    check("ackhigh_state", 32'(dbg_state), 32'(aer_pkg::IDLE));
    check("ackhigh_busy", 32'(aerin_ctrl_busy), 32'd0);
    aerin_ack = 1'b0;
    auto_ack = 1'b1;
    plan_q.push_back(aer_pkg::AER_RST_ADDR);
    drain("ackhigh", 500);
    check("ackhigh_cnt", 32'(evt_cnt), 32'd1);

`ifdef AER_TIMEOUT_EN
    // ACK never comes for the first event; the second proceeds normally
    apply_reset(1'b0);
    ack_hold = 1'b1;
    exp_q.push_back(10'h032);
    burst(49, 2);
    k = 0;
    while (!aerin_req && k < 20) begin step(); k++; end
    check("to_req_seen", 32'(aerin_req), 32'd1);
    check("to_lost_addr", 32'(aerin_addr), 32'h031);
    h = 0;
    while (aerin_req && h < 50) begin h++; step(); end
    check("to_req_high", 32'(h), 32'(ACK_TIMEOUT));
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_cnt_unchanged", 32'(evt_cnt), 32'd0);
    ack_hold = 1'b0;
    drain("to_next", 500);
    check("to_next_cnt", 32'(evt_cnt), 32'd1);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
`else
    check("no_timeout_err", 32'(timeout_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
